// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the frame-lock state encoding,
// shared by the sync pulse generator and the porch/sync regenerator.
package vga_timing_pkg;

  localparam int VGA_TOTAL_COL     = 800;
  localparam int VGA_TOTAL_ROW     = 525;
  localparam int VGA_ACTIVE_COL    = 640;
  localparam int VGA_ACTIVE_ROW    = 480;
  localparam int VGA_H_FRONT_PORCH = 16;
  localparam int VGA_H_BACK_PORCH  = 48;
  localparam int VGA_V_FRONT_PORCH = 10;
  localparam int VGA_V_BACK_PORCH  = 33;
  localparam int VGA_VIDEO_WIDTH   = 3;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ARMED    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

endpackage

// File: rtl/vga_sync_to_count.sv
// Frame-start detection, free-running column/row counters and frame lock tracking.
//
// state    | meaning
// UNLOCKED | no frame start seen since reset
// ARMED    | counters seeded by a frame start, waiting for one that confirms them
// LOCKED   | last frame start arrived exactly where the counters wrapped
module vga_sync_to_count
  import vga_timing_pkg::*;
#(
  parameter int TOTAL_COL = VGA_TOTAL_COL,
  parameter int TOTAL_ROW = VGA_TOTAL_ROW,
  parameter int COL_W     = $clog2(TOTAL_COL),
  parameter int ROW_W     = $clog2(TOTAL_ROW)
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_V_Sync,
  output logic [COL_W-1:0] o_Col,
  output logic [ROW_W-1:0] o_Row,
  output logic             o_Frame_Start,
  output logic             o_Locked
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(TOTAL_COL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TOTAL_ROW - 1);

  logic             v_sync_q, v_sync_d;
  logic             fs_q, fs_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  lock_state_e      state_q, state_d;

  logic frame_start;
  logic col_wrap;
  logic at_frame_end;

  always_comb begin
    frame_start  = i_V_Sync & ~v_sync_q;
    col_wrap     = (col_q == COL_LAST);
    at_frame_end = col_wrap && (row_q == ROW_LAST);

    v_sync_d = i_V_Sync;
    fs_d     = frame_start;
    col_d    = col_q;
    row_d    = row_q;

    // A frame start always reseeds; when it coincides with the natural wrap
    // the loaded value equals the wrapped one, so outputs do not glitch.
    if (frame_start) begin
      col_d = '0;
      row_d = '0;
    end else if (col_wrap) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end else begin
      col_d = col_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      UNLOCKED: if (frame_start)                  state_d = ARMED;
      ARMED:    if (frame_start && at_frame_end)  state_d = LOCKED;
      LOCKED:   if (frame_start && !at_frame_end) state_d = ARMED;
      default:                                    state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      v_sync_q <= 1'b0;
      fs_q     <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      state_q  <= UNLOCKED;
    end else begin
      v_sync_q <= v_sync_d;
      fs_q     <= fs_d;
      col_q    <= col_d;
      row_q    <= row_d;
      state_q  <= state_d;
    end
  end

  assign o_Col         = col_q;
  assign o_Row         = row_q;
  assign o_Frame_Start = fs_q;
  assign o_Locked      = (state_q == LOCKED);

endmodule

// File: rtl/vga_sync_porch.sv
// Regenerates VGA sync pulses with porches from upstream active-area flags and
// blanks RGB outside the visible area; every output is two cycles behind its input.
module vga_sync_porch
  import vga_timing_pkg::*;
#(
  parameter int TOTAL_COL     = VGA_TOTAL_COL,
  parameter int TOTAL_ROW     = VGA_TOTAL_ROW,
  parameter int ACTIVE_COL    = VGA_ACTIVE_COL,
  parameter int ACTIVE_ROW    = VGA_ACTIVE_ROW,
  parameter int H_FRONT_PORCH = VGA_H_FRONT_PORCH,
  parameter int H_BACK_PORCH  = VGA_H_BACK_PORCH,
  parameter int V_FRONT_PORCH = VGA_V_FRONT_PORCH,
  parameter int V_BACK_PORCH  = VGA_V_BACK_PORCH,
  parameter int VIDEO_WIDTH   = VGA_VIDEO_WIDTH
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_H_Sync,
  input  logic                   i_V_Sync,
  input  logic [VIDEO_WIDTH-1:0] i_Red,
  input  logic [VIDEO_WIDTH-1:0] i_Grn,
  input  logic [VIDEO_WIDTH-1:0] i_Blu,
  output logic                   o_H_Sync,
  output logic                   o_V_Sync,
  output logic [VIDEO_WIDTH-1:0] o_Red,
  output logic [VIDEO_WIDTH-1:0] o_Grn,
  output logic [VIDEO_WIDTH-1:0] o_Blu,
  output logic                   o_Frame_Start,
  output logic                   o_Locked
);

  localparam int COL_W = $clog2(TOTAL_COL);
  localparam int ROW_W = $clog2(TOTAL_ROW);

  localparam logic [COL_W-1:0] H_PULSE_FIRST = COL_W'(ACTIVE_COL + H_FRONT_PORCH);
  localparam logic [COL_W-1:0] H_PULSE_LAST  = COL_W'(TOTAL_COL - H_BACK_PORCH - 1);
  localparam logic [ROW_W-1:0] V_PULSE_FIRST = ROW_W'(ACTIVE_ROW + V_FRONT_PORCH);
  localparam logic [ROW_W-1:0] V_PULSE_LAST  = ROW_W'(TOTAL_ROW - V_BACK_PORCH - 1);
  localparam logic [COL_W-1:0] COL_VISIBLE   = COL_W'(ACTIVE_COL);
  localparam logic [ROW_W-1:0] ROW_VISIBLE   = ROW_W'(ACTIVE_ROW);

  // Column position comes from the counters, so the horizontal flag carries no extra information.
  logic unused_h_sync;
  assign unused_h_sync = i_H_Sync;

  logic [COL_W-1:0] col_s1;
  logic [ROW_W-1:0] row_s1;
  logic             fs_s1;
  logic             locked_s1;

  vga_sync_to_count #(
    .TOTAL_COL (TOTAL_COL),
    .TOTAL_ROW (TOTAL_ROW),
    .COL_W     (COL_W),
    .ROW_W     (ROW_W)
  ) u_count (
    .i_Clk         (i_Clk),
    .i_Reset       (i_Reset),
    .i_V_Sync      (i_V_Sync),
    .o_Col         (col_s1),
    .o_Row         (row_s1),
    .o_Frame_Start (fs_s1),
    .o_Locked      (locked_s1)
  );

  logic [VIDEO_WIDTH-1:0] red_s1_q, red_s1_d;
  logic [VIDEO_WIDTH-1:0] grn_s1_q, grn_s1_d;
  logic [VIDEO_WIDTH-1:0] blu_s1_q, blu_s1_d;

  logic                   h_sync_q, h_sync_d;
  logic                   v_sync_q, v_sync_d;
  logic [VIDEO_WIDTH-1:0] red_q, red_d;
  logic [VIDEO_WIDTH-1:0] grn_q, grn_d;
  logic [VIDEO_WIDTH-1:0] blu_q, blu_d;
  logic                   frame_start_q, frame_start_d;
  logic                   locked_q, locked_d;

  logic h_pulse;
  logic v_pulse;
  logic visible;

  always_comb begin
    red_s1_d = i_Red;
    grn_s1_d = i_Grn;
    blu_s1_d = i_Blu;

    h_pulse = (col_s1 >= H_PULSE_FIRST) && (col_s1 <= H_PULSE_LAST);
    v_pulse = (row_s1 >= V_PULSE_FIRST) && (row_s1 <= V_PULSE_LAST);
    visible = (col_s1 < COL_VISIBLE) && (row_s1 < ROW_VISIBLE);

    // Until the counters are trusted the monitor sees idle syncs and black.
    h_sync_d      = ~(locked_s1 & h_pulse);
    v_sync_d      = ~(locked_s1 & v_pulse);
    red_d         = (locked_s1 && visible) ? red_s1_q : '0;
    grn_d         = (locked_s1 && visible) ? grn_s1_q : '0;
    blu_d         = (locked_s1 && visible) ? blu_s1_q : '0;
    frame_start_d = fs_s1;
    locked_d      = locked_s1;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      red_s1_q      <= '0;
      grn_s1_q      <= '0;
      blu_s1_q      <= '0;
      h_sync_q      <= 1'b1;
      v_sync_q      <= 1'b1;
      red_q         <= '0;
      grn_q         <= '0;
      blu_q         <= '0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      red_s1_q      <= red_s1_d;
      grn_s1_q      <= grn_s1_d;
      blu_s1_q      <= blu_s1_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      red_q         <= red_d;
      grn_q         <= grn_d;
      blu_q         <= blu_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
    end
  end

  assign o_H_Sync      = h_sync_q;
  assign o_V_Sync      = v_sync_q;
  assign o_Red         = red_q;
  assign o_Grn         = grn_q;
  assign o_Blu         = blu_q;
  assign o_Frame_Start = frame_start_q;
  assign o_Locked      = locked_q;

endmodule

// File: tb/tb_vga_sync_porch.sv
// Bench for vga_sync_porch on a shrunken raster: an upstream position counter
// drives the flags, and a position/lock model predicts every output two cycles later.
module tb_vga_sync_porch;

  localparam int TC  = 20;
  localparam int TR  = 12;
  localparam int AC  = 12;
  localparam int AR  = 8;
  localparam int HFP = 2;
  localparam int HBP = 3;
  localparam int VFP = 1;
  localparam int VBP = 2;
  localparam int VW  = 3;
  localparam int F   = TC * TR;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_H_Sync, i_V_Sync;
  logic [VW-1:0] i_Red, i_Grn, i_Blu;
  logic          o_H_Sync, o_V_Sync;
  logic [VW-1:0] o_Red, o_Grn, o_Blu;
  logic          o_Frame_Start, o_Locked;

  always #5 clk = ~clk;

  vga_sync_porch #(
    .TOTAL_COL(TC), .TOTAL_ROW(TR), .ACTIVE_COL(AC), .ACTIVE_ROW(AR),
    .H_FRONT_PORCH(HFP), .H_BACK_PORCH(HBP), .V_FRONT_PORCH(VFP), .V_BACK_PORCH(VBP),
    .VIDEO_WIDTH(VW)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_H_Sync(i_H_Sync), .i_V_Sync(i_V_Sync),
    .i_Red(i_Red), .i_Grn(i_Grn), .i_Blu(i_Blu),
    .o_H_Sync(o_H_Sync), .o_V_Sync(o_V_Sync),
    .o_Red(o_Red), .o_Grn(o_Grn), .o_Blu(o_Blu),
    .o_Frame_Start(o_Frame_Start), .o_Locked(o_Locked)
  );

  typedef struct packed {
    logic          h;
    logic          v;
    logic [VW-1:0] r;
    logic [VW-1:0] g;
    logic [VW-1:0] b;
    logic          fs;
    logic          lk;
  } out_t;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  out_t exp_q[$];
  out_t exp_o;

  // upstream generator: raster position, and a hold that models it sitting in reset
  int            upos = 0;
  int            hold_cnt = 0;
  bit            red_fixed = 1'b0;
  logic [VW-1:0] red_val = '0;

  // reference: position inside the frame as one linear index, plus lock level 0/1/2
  bit m_vprev;
  int m_pos;
  int m_lock;

  function automatic out_t reset_out();
    out_t o;
    o.h = 1'b1; o.v = 1'b1; o.r = '0; o.g = '0; o.b = '0; o.fs = 1'b0; o.lk = 1'b0;
    return o;
  endfunction

  function automatic out_t actual();
    out_t o;
    o = {o_H_Sync, o_V_Sync, o_Red, o_Grn, o_Blu, o_Frame_Start, o_Locked};
    return o;
  endfunction

  function automatic int first_after(input int q[$], input int t);
    foreach (q[i]) if (q[i] > t) return q[i];
    return -1;
  endfunction

  task automatic drive_inputs();
    int col, row;
    col = upos % TC;
    row = upos / TC;
    i_H_Sync = (hold_cnt == 0) && (col < AC);
    i_V_Sync = (hold_cnt == 0) && (row < AR);
    i_Red = red_fixed ? red_val : VW'($urandom);
    i_Grn = VW'($urandom);
    i_Blu = VW'($urandom);
  endtask

  task automatic model_reset();
    m_vprev = 1'b0;
    m_pos   = 0;
    m_lock  = 0;
    exp_q.delete();
    exp_q.push_back(reset_out());
  endtask

  task automatic model_step();
    bit   fs, was_last, lk, vis;
    int   col, row;
    out_t o;
    fs       = i_V_Sync && !m_vprev;
    was_last = (m_pos == F - 1);
    m_vprev  = i_V_Sync;
    if (fs) begin
      if (m_lock == 0) m_lock = 1;
      else if (m_lock == 1) begin if (was_last) m_lock = 2; end
      else if (!was_last) m_lock = 1;
    end
    m_pos = fs ? 0 : (m_pos + 1) % F;
    col = m_pos % TC;
    row = m_pos / TC;
    lk  = (m_lock == 2);
    vis = lk && (col < AC) && (row < AR);
    o.h  = !(lk && col >= AC + HFP && col <= TC - HBP - 1);
    o.v  = !(lk && row >= AR + VFP && row <= TR - VBP - 1);
    o.r  = vis ? i_Red : '0;
    o.g  = vis ? i_Grn : '0;
    o.b  = vis ? i_Blu : '0;
    o.fs = fs;
    o.lk = lk;
    exp_q.push_back(o);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    exp_o = exp_q.pop_front();
    if (hold_cnt > 0) begin
      hold_cnt--;
      upos = 0;
    end else begin
      upos = (upos + 1) % F;
    end
    drive_inputs();
  endtask

  task automatic test_power_on();
    rst = 1'b1;
    hold_cnt = 1000;
    upos = 0;
    drive_inputs();
    @(posedge clk);
    #1;
    checks++;
    if (actual() !== reset_out()) begin
      errors++;
      $display("FAIL power_on_reset got=%h exp=%h", actual(), reset_out());
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (actual() !== exp_o) begin
        errors++;
        $display("FAIL stream_power_on cyc=%0d got=%h exp=%h", cyc, actual(), exp_o);
      end
    end
  endtask

  task automatic test_lock_acquire();
    int first_fs = -1;
    int first_lk = -1;
    int early_h_low = 0;
    hold_cnt = 3;
    upos = 0;
    drive_inputs();
    for (int n = 0; n < 3 * F && first_lk < 0; n++) begin
      tick();
      checks++;
      if (actual() !== exp_o) begin
        errors++;
        $display("FAIL stream_lock cyc=%0d got=%h exp=%h", cyc, actual(), exp_o);
      end
      if (o_Frame_Start && first_fs < 0) first_fs = cyc;
      if (o_Locked && first_lk < 0) first_lk = cyc;
      if (first_fs >= 0 && first_lk < 0 && (!o_H_Sync || !o_V_Sync || o_Red != 0)) early_h_low++;
    end
    checks++;
    if (first_lk < 0 || first_fs < 0 || first_lk - first_fs != F) begin
      errors++;
      $display("FAIL lock_after_second_fs got=%0d exp=%0d", first_lk - first_fs, F);
    end
    checks++;
    if (early_h_low != 0) begin
      errors++;
      $display("FAIL armed_outputs_idle got=%0d exp=0", early_h_low);
    end
  endtask

  task automatic test_sync_timing();
    int   hf[$], hr[$], vf[$], vr[$], fsq[$];
    logic ph, pv;
    int   a, b, c, va, vb, vc;
    ph = o_H_Sync;
    pv = o_V_Sync;
    for (int n = 0; n < 3 * F; n++) begin
      tick();
      checks++;
      if (actual() !== exp_o) begin
        errors++;
        $display("FAIL stream_timing cyc=%0d got=%h exp=%h", cyc, actual(), exp_o);
      end
      if (ph && !o_H_Sync) hf.push_back(cyc);
      if (!ph && o_H_Sync) hr.push_back(cyc);
      if (pv && !o_V_Sync) vf.push_back(cyc);
      if (!pv && o_V_Sync) vr.push_back(cyc);
      if (o_Frame_Start) fsq.push_back(cyc);
      ph = o_H_Sync;
      pv = o_V_Sync;
    end
    if (fsq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL timing_no_frame_start got=0 exp=1");
    end else begin
      a  = first_after(hf, fsq[0]);
      b  = first_after(hr, a);
      c  = first_after(hf, a);
      va = first_after(vf, fsq[0]);
      vb = first_after(vr, va);
      vc = first_after(vf, va);
      checks++;
      if (a < 0 || a - fsq[0] != AC + HFP) begin
        errors++;
        $display("FAIL h_pulse_start got=%0d exp=%0d", a - fsq[0], AC + HFP);
      end
      checks++;
      if (b < 0 || b - a != TC - HBP - (AC + HFP)) begin
        errors++;
        $display("FAIL h_pulse_width got=%0d exp=%0d", b - a, TC - HBP - (AC + HFP));
      end
      checks++;
      if (c < 0 || c - a != TC) begin
        errors++;
        $display("FAIL h_period got=%0d exp=%0d", c - a, TC);
      end
      checks++;
      if (va < 0 || va - fsq[0] != (AR + VFP) * TC) begin
        errors++;
        $display("FAIL v_pulse_start got=%0d exp=%0d", va - fsq[0], (AR + VFP) * TC);
      end
      checks++;
      if (vb < 0 || vb - va != (TR - VBP - (AR + VFP)) * TC) begin
        errors++;
        $display("FAIL v_pulse_width got=%0d exp=%0d", vb - va, (TR - VBP - (AR + VFP)) * TC);
      end
      checks++;
      if (vc < 0 || vc - va != F) begin
        errors++;
        $display("FAIL v_period got=%0d exp=%0d", vc - va, F);
      end
    end
  endtask

  task automatic test_pixel_origin();
    for (int n = 0; n < F + 5 && !(upos == 0 && hold_cnt == 0); n++) begin
      tick();
      checks++;
      if (actual() !== exp_o) begin
        errors++;
        $display("FAIL stream_origin_wait cyc=%0d got=%h exp=%h", cyc, actual(), exp_o);
      end
    end
    i_Red = 3'b101;
    repeat (2) begin
      tick();
      checks++;
      if (actual() !== exp_o) begin
        errors++;
        $display("FAIL stream_origin cyc=%0d got=%h exp=%h", cyc, actual(), exp_o);
      end
    end
    checks++;
    if (o_Red !== 3'b101 || o_Frame_Start !== 1'b1) begin
      errors++;
      $display("FAIL origin_pixel got=red %b fs %b exp=red 101 fs 1", o_Red, o_Frame_Start);
    end
  endtask

  task automatic test_blanking();
    int lit = 0;
    int dark = 0;
    red_fixed = 1'b1;
    red_val = 3'd7;
    i_Red = 3'd7;
    for (int n = 0; n < F + 2; n++) begin
      tick();
      checks++;
      if (actual() !== exp_o) begin
        errors++;
        $display("FAIL stream_blank cyc=%0d got=%h exp=%h", cyc, actual(), exp_o);
      end
      if (n >= 2) begin
        if (o_Red === 3'd7) lit++;
        else if (o_Red === 3'd0) dark++;
      end
    end
    red_fixed = 1'b0;
    checks++;
    if (lit != AC * AR || dark != F - AC * AR) begin
      errors++;
      $display("FAIL blank_counts got=lit %0d dark %0d exp=lit %0d dark %0d", lit, dark, AC * AR, F - AC * AR);
    end
  endtask

  task automatic test_early_fs();
    int sync_low = 0;
    for (int n = 0; n < F + 5 && upos != 6 * TC + 5; n++) begin
      tick();
      checks++;
      if (actual() !== exp_o) begin
        errors++;
        $display("FAIL stream_early_wait cyc=%0d got=%h exp=%h", cyc, actual(), exp_o);
      end
    end
    hold_cnt = 2;
    upos = 0;
    drive_inputs();
    repeat (3) begin
      tick();
      checks++;
      if (actual() !== exp_o) begin
        errors++;
        $display("FAIL stream_early cyc=%0d got=%h exp=%h", cyc, actual(), exp_o);
      end
    end
    checks++;
    if (o_Locked !== 1'b1) begin
      errors++;
      $display("FAIL early_lock_before_drop got=%b exp=1", o_Locked);
    end
    tick();
    checks++;
    if (o_Locked !== 1'b0 || o_Frame_Start !== 1'b1 || o_H_Sync !== 1'b1 || o_V_Sync !== 1'b1) begin
      errors++;
      $display("FAIL early_lock_drop got=lk %b fs %b h %b v %b exp=lk 0 fs 1 h 1 v 1",
               o_Locked, o_Frame_Start, o_H_Sync, o_V_Sync);
    end
    for (int n = 0; n < F - 1; n++) begin
      tick();
      checks++;
      if (actual() !== exp_o) begin
        errors++;
        $display("FAIL stream_rearmed cyc=%0d got=%h exp=%h", cyc, actual(), exp_o);
      end
      if (!o_H_Sync || !o_V_Sync || o_Locked) sync_low++;
    end
    checks++;
    if (sync_low != 0) begin
      errors++;
      $display("FAIL rearmed_syncs_held got=%0d exp=0", sync_low);
    end
    tick();
    checks++;
    if (o_Locked !== 1'b1) begin
      errors++;
      $display("FAIL early_relock got=%b exp=1", o_Locked);
    end
  endtask

  task automatic test_stall();
    for (int n = 0; n < F + 5 && upos != 3 * TC; n++) begin
      tick();
      checks++;
      if (actual() !== exp_o) begin
        errors++;
        $display("FAIL stream_stall_wait cyc=%0d got=%h exp=%h", cyc, actual(), exp_o);
      end
    end
    hold_cnt = F + 37;
    upos = 0;
    drive_inputs();
    for (int n = 0; n < F + 37; n++) begin
      tick();
      checks++;
      if (actual() !== exp_o) begin
        errors++;
        $display("FAIL stream_stall cyc=%0d got=%h exp=%h", cyc, actual(), exp_o);
      end
    end
    checks++;
    if (o_Locked !== 1'b1) begin
      errors++;
      $display("FAIL stall_lock_held got=%b exp=1", o_Locked);
    end
    for (int n = 0; n < 2 * F + 2; n++) begin
      tick();
      checks++;
      if (actual() !== exp_o) begin
        errors++;
        $display("FAIL stream_after_stall cyc=%0d got=%h exp=%h", cyc, actual(), exp_o);
      end
    end
    checks++;
    if (o_Locked !== 1'b1) begin
      errors++;
      $display("FAIL stall_relock got=%b exp=1", o_Locked);
    end
  endtask

  task automatic test_reset();
    bit got_lock = 1'b0;
    for (int n = 0; n < F + 5 && upos != 4 * TC + 7; n++) begin
      tick();
      checks++;
      if (actual() !== exp_o) begin
        errors++;
        $display("FAIL stream_reset_wait cyc=%0d got=%h exp=%h", cyc, actual(), exp_o);
      end
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (o_H_Sync !== 1'b1 || o_V_Sync !== 1'b1 || o_Red !== '0 || o_Grn !== '0 ||
        o_Blu !== '0 || o_Locked !== 1'b0 || o_Frame_Start !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", actual(), reset_out());
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      upos = (upos + 1) % F;
      drive_inputs();
      checks++;
      if (actual() !== reset_out()) begin
        errors++;
        $display("FAIL reset_held got=%h exp=%h", actual(), reset_out());
      end
    end
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 4 * F && !got_lock; n++) begin
      tick();
      checks++;
      if (actual() !== exp_o) begin
        errors++;
        $display("FAIL stream_after_reset cyc=%0d got=%h exp=%h", cyc, actual(), exp_o);
      end
      if (o_Locked) got_lock = 1'b1;
    end
    checks++;
    if (!got_lock) begin
      errors++;
      $display("FAIL reset_relock_timeout got=0 exp=1");
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8 * F; n++) begin
      if (hold_cnt == 0 && $urandom_range(0, 199) == 0) begin
        hold_cnt = $urandom_range(1, 4);
        upos = 0;
        drive_inputs();
      end
      tick();
      checks++;
      if (actual() !== exp_o) begin
        errors++;
        $display("FAIL stream_random cyc=%0d got=%h exp=%h", cyc, actual(), exp_o);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_power_on();
    test_lock_acquire();
    test_sync_timing();
    test_pixel_origin();
    test_blanking();
    test_early_fs();
    test_stall();
    test_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
